// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Holds the op encodings, the FSM state enum and the default datapath width.
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;

    // EX-stage op encodings on the op port
    typedef enum logic [1:0] {
        MDU_DIV   = 2'b00,
        MDU_DIVU  = 2'b01,
        MDU_MULT  = 2'b10,
        MDU_MULTU = 2'b11
    } mdu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DIV  = 3'd1,
        ST_FIX  = 3'd2,
        ST_MUL  = 3'd3,
        ST_DONE = 3'd4
    } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring radix-2 division step (combinational).
// Ports:
//   rem       partial remainder (always < divisor)
//   dbit      next dividend bit shifted in
//   divisor   divisor magnitude
//   rem_nxt_c next partial remainder
//   qbit_c    quotient bit produced by this step
module mdu_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dbit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nxt_c,
    output logic             qbit_c
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] diff;

    // The shifted remainder is WIDTH+1 bits wide; its top bit alone makes it
    // exceed any divisor, and the true difference always fits in WIDTH bits.
    always_comb begin
        shifted   = {rem[WIDTH-2:0], dbit};
        diff      = shifted - divisor;
        qbit_c    = rem[WIDTH-1] | (shifted >= divisor);
        rem_nxt_c = qbit_c ? diff : shifted;
    end

endmodule

// File: rtl/hilo_mdu.sv
// Multi-cycle multiply/divide unit feeding the HI/LO register pair.
// Divides in WIDTH iterations plus a sign-fix cycle; multiplies in one cycle
// when built with MDU_MULT_EN (otherwise MULT/MULTU requests are ignored).
// Ports:
//   clk, resetn          clock, async active-low reset
//   start, op            request and operation (accepted only when idle)
//   src_a, src_b         rs / rt operands
//   flush                cancel any in-flight op
//   busy                 op in flight (pipeline stall)
//   done                 one-cycle result pulse
//   hi_wen, hi_wdata     HI write: remainder / product upper half
//   lo_wen, lo_wdata     LO write: quotient / product lower half
module hilo_mdu
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             hi_wen,
    output logic [WIDTH-1:0] hi_wdata,
    output logic             lo_wen,
    output logic [WIDTH-1:0] lo_wdata
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mdu_state_e       state_q, state_nxt;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;       // raw src_a
    logic [WIDTH-1:0] b_q;       // |src_b| for divide, raw src_b for multiply
    logic [WIDTH-1:0] quo_q;     // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] rem_q;
    logic             sgn_q, neg_q, aneg_q, bzero_q;

    logic             accept;
    logic             mult_req, op_signed, op_ok;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH-1:0] rem_step_c;
    logic             qbit_step_c;
    logic [WIDTH-1:0] q_fix, r_fix;

    mdu_div_step #(.WIDTH(WIDTH)) u_step (
        .rem       (rem_q),
        .dbit      (quo_q[WIDTH-1]),
        .divisor   (b_q),
        .rem_nxt_c (rem_step_c),
        .qbit_c    (qbit_step_c)
    );

    // Request decode and operand magnitudes
    always_comb begin
        mult_req  = (op == MDU_MULT) || (op == MDU_MULTU);
        op_signed = (op == MDU_DIV) || (op == MDU_MULT);
`ifdef MDU_MULT_EN
        op_ok     = 1'b1;
`else
        op_ok     = !mult_req;
`endif
        a_abs = (op_signed && src_a[WIDTH-1]) ? (~src_a + WIDTH'(1)) : src_a;
        b_abs = (op_signed && src_b[WIDTH-1]) ? (~src_b + WIDTH'(1)) : src_b;
    end

    // Sign fix-up; a zero divisor bypasses it with the architected result
    always_comb begin
        q_fix = (sgn_q && neg_q)  ? (~quo_q + WIDTH'(1)) : quo_q;
        r_fix = (sgn_q && aneg_q) ? (~rem_q + WIDTH'(1)) : rem_q;
        if (bzero_q) begin
            q_fix = '1;
            r_fix = a_q;
        end
    end

`ifdef MDU_MULT_EN
    logic [2*WIDTH-1:0] ax_c, bx_c, prod_c;

    // Full-width product via sign/zero extension to 2*WIDTH
    always_comb begin
        ax_c   = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
        bx_c   = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
        prod_c = ax_c * bx_c;
    end
`endif

    // Next-state logic; flush overrides everything
    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !flush && op_ok) begin
                    accept = 1'b1;
`ifdef MDU_MULT_EN
                    state_nxt = mult_req ? ST_MUL : ST_DIV;
`else
                    state_nxt = ST_DIV;
`endif
                end
            end
            ST_DIV:  if (cnt_q == CW'(WIDTH - 1)) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_MUL:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (flush && (state_q != ST_IDLE)) begin
            state_nxt = ST_IDLE;
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi_wen   <= 1'b0;
            lo_wen   <= 1'b0;
            hi_wdata <= '0;
            lo_wdata <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            sgn_q    <= 1'b0;
            neg_q    <= 1'b0;
            aneg_q   <= 1'b0;
            bzero_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            busy    <= (state_nxt != ST_IDLE);
            done    <= (state_nxt == ST_DONE);
            hi_wen  <= (state_nxt == ST_DONE);
            lo_wen  <= (state_nxt == ST_DONE);

            if (accept) begin
                a_q     <= src_a;
                b_q     <= mult_req ? src_b : b_abs;
                quo_q   <= a_abs;
                rem_q   <= '0;
                cnt_q   <= '0;
                sgn_q   <= op_signed;
                neg_q   <= src_a[WIDTH-1] ^ src_b[WIDTH-1];
                aneg_q  <= src_a[WIDTH-1];
                bzero_q <= (src_b == '0);
            end else if (state_q == ST_DIV) begin
                rem_q <= rem_step_c;
                quo_q <= {quo_q[WIDTH-2:0], qbit_step_c};
                cnt_q <= cnt_q + CW'(1);
            end

            if ((state_q == ST_FIX) && (state_nxt == ST_DONE)) begin
                hi_wdata <= r_fix;
                lo_wdata <= q_fix;
            end
`ifdef MDU_MULT_EN
            if ((state_q == ST_MUL) && (state_nxt == ST_DONE)) begin
                hi_wdata <= prod_c[2*WIDTH-1:WIDTH];
                lo_wdata <= prod_c[WIDTH-1:0];
            end
`endif
        end
    end

endmodule

// File: tb/tb_hilo_mdu.sv
// Self-checking bench for hilo_mdu: directed vectors push expected HI/LO and
// the cycle of the done pulse into a scoreboard; a monitor pops on done.
module tb_hilo_mdu;
    import mdu_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic         flush;
    logic [1:0]   op;
    logic [W-1:0] src_a, src_b;
    logic         busy, done, hi_wen, lo_wen;
    logic [W-1:0] hi_wdata, lo_wdata;

    hilo_mdu #(.WIDTH(W)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .hi_wen   (hi_wen),
        .hi_wdata (hi_wdata),
        .lo_wen   (lo_wen),
        .lo_wdata (lo_wdata)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (resetn && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no result", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi_wdata", 64'(hi_wdata), 64'(e.hi));
                chk("lo_wdata", 64'(lo_wdata), 64'(e.lo));
                chk("done_cycle", 64'(cyc), 64'(e.due));
                chk("wen", 64'({hi_wen, lo_wen}), 64'(2'b11));
            end
        end else if (resetn && (hi_wen || lo_wen)) begin
            checks++;
            errors++;
            $display("FAIL wen_without_done: got wen=%b%b expected 00", hi_wen, lo_wen);
        end
    end

    // Issue one op; optionally inject an ignored start at inj_at and a flush
    // at flush_at (cycles counted from the accepting edge).
    task automatic run_op(input string name, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int lat, input int inj_at, input int flush_at);
        int k;
        int bcnt;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        if (flush_at == 0) sb.push_back('{hi: ehi, lo: elo, due: 32'(cyc) + 32'(lat)});
        k    = 0;
        bcnt = 0;
        while (k < 100) begin
            @(negedge clk);
            k++;
            if (!busy) break;
            bcnt++;
            if (k == 1) begin
                src_a = ~a;
                src_b = b + 32'd3;
            end
            start = (k == inj_at);
            flush = (k == flush_at);
        end
        start = 1'b0;
        flush = 1'b0;
        chk({name, "_busy_cycles"}, 64'(bcnt), 64'((flush_at != 0) ? flush_at : lat));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        op     = 2'b00;
        src_a  = '0;
        src_b  = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 64'({busy, done, hi_wen, lo_wen}), 64'(4'b0));
        chk("reset_data", {hi_wdata, lo_wdata}, 64'(0));
        resetn = 1'b1;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'(0));

        run_op("divu_100_7",  MDU_DIVU, 32'd100,        32'd7,          32'd2,          32'd14,         34, 5, 0);
        run_op("div_m7_2",    MDU_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  34, 0, 0);
        run_op("div_7_m2",    MDU_DIV,  32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD,  34, 0, 0);
        run_op("div_ovf",     MDU_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  34, 0, 0);
        run_op("divu_5_0",    MDU_DIVU, 32'd5,          32'd0,          32'd5,          32'hFFFF_FFFF,  34, 0, 0);
        run_op("div_m5_0",    MDU_DIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  32'hFFFF_FFFF,  34, 0, 0);
        run_op("divu_max_1",  MDU_DIVU, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'hFFFF_FFFF,  34, 0, 0);
        run_op("divu_flush",  MDU_DIVU, 32'd100,        32'd7,          32'd0,          32'd0,          34, 5, 10);
        run_op("divu_big",    MDU_DIVU, 32'h1234_5678,  32'd1000,       32'h0000_0380,  32'h0004_A90B,  34, 0, 0);
        run_op("div_m100_m7", MDU_DIV,  32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd14,         34, 0, 0);

`ifdef MDU_MULT_EN
        run_op("mult_m1_2",   MDU_MULT,  32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 0, 0);
        run_op("multu_m1_2",  MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1,         32'hFFFF_FFFE, 2, 0, 0);
        run_op("mult_m3_m5",  MDU_MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd0, 32'd15,        2, 0, 0);
`else
        @(negedge clk);
        start = 1'b1;
        op    = MDU_MULT;
        src_a = 32'hFFFF_FFFF;
        src_b = 32'd2;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("mult_off_busy", 64'(busy), 64'(0));
            @(negedge clk);
        end
`endif

        // Async reset in the middle of a divide
        @(negedge clk);
        start = 1'b1;
        op    = MDU_DIVU;
        src_a = 32'd1000;
        src_b = 32'd3;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_rst_busy", 64'(busy), 64'(1));
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_ctrl", 64'({busy, done, hi_wen, lo_wen}), 64'(4'b0));
        chk("async_rst_data", {hi_wdata, lo_wdata}, 64'(0));
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'(0));
        repeat (40) @(negedge clk);

        run_op("divu_after_rst", MDU_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, 34, 0, 0);

        repeat (5) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
